radix4_seq_divider: RTL and testbench

//  Sequential signed radix-4 restoring divider; the inverse of the 8x8 Booth multiply path.

---
 rtl/arith_pkg.sv | 14 +
 rtl/radix4_div_step.sv | 38 +++
 rtl/radix4_seq_divider.sv | 167 ++++++++++++++++
 tb/tb_radix4_seq_divider.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding, default datapath
// width and the signed saturation magnitude used by the divider and Booth multiplier.
package arith_pkg;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_e;

  localparam int unsigned DW_DEF = 8;

  // 2^(dw-1): magnitude of the most negative dw-bit value; max positive is one less.
  function automatic int unsigned sat_mag(input int unsigned dw);
    return 32'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/radix4_div_step.sv
// One radix-4 restoring step: picks the largest digit k in {3,2,1,0} with
// k*|D| <= {R, two dividend bits} and returns the reduced partial remainder.
module radix4_div_step
  import arith_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [DW:0]   r_i,
  input  logic [1:0]    bits_i,
  input  logic [DW:0]   d1_i,
  input  logic [DW+1:0] d2_i,
  input  logic [DW+1:0] d3_i,
  output logic [DW:0]   r_o,
  output logic [1:0]    digit_o
);

  localparam int unsigned RW = DW + 1;

  logic [DW+2:0] t;

  always_comb begin
    t = {r_i, bits_i};
    if (t >= {1'b0, d3_i}) begin
      digit_o = 2'd3;
      r_o     = RW'(t - {1'b0, d3_i});
    end else if (t >= {1'b0, d2_i}) begin
      digit_o = 2'd2;
      r_o     = RW'(t - {1'b0, d2_i});
    end else if (t >= {2'b00, d1_i}) begin
      digit_o = 2'd1;
      r_o     = RW'(t - {2'b00, d1_i});
    end else begin
      digit_o = 2'd0;
      r_o     = RW'(t);
    end
  end

endmodule

// File: rtl/radix4_seq_divider.sv
// Sequential signed 2*DW / DW divider, two quotient bits per cycle, with
// valid/ready handshakes on operand and result sides.
module radix4_seq_divider
  import arith_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero,
  output logic            overflow
);

  localparam int unsigned NSTEPS = DW / 2;
  localparam int unsigned CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CW-1:0] LAST  = CW'(NSTEPS - 1);
  localparam logic [DW-1:0] Q_MAX = DW'(sat_mag(DW) - 1);
  localparam logic [DW-1:0] Q_MIN = DW'(sat_mag(DW));

  state_e          state_q;
  logic            in_ready_q, out_valid_q;
  logic [DW-1:0]   quot_q, remo_q;
  logic            dzo_q, ovfo_q;

  logic [2*DW-1:0] n_q;
  logic [DW-1:0]   d_q;
  logic [DW:0]     absd_q;
  logic [DW+1:0]   d3_q;
  logic [DW:0]     rem_q;
  logic [DW-1:0]   lo_q, qu_q;
  logic [CW-1:0]   cnt_q;
  logic            sn_q, sd_q, dz_q, povf_q;

  logic [2*DW-1:0] absn_d;
  logic [DW:0]     dext, absd_d;
  logic [DW+1:0]   d3_d;
  logic            dz_d, povf_d;

  always_comb begin
    absn_d = n_q[2*DW-1] ? -n_q : n_q;
    dext   = {d_q[DW-1], d_q};
    absd_d = d_q[DW-1] ? -dext : dext;
    d3_d   = {1'b0, absd_d} + {absd_d, 1'b0};
    dz_d   = (d_q == '0);
    // High half >= |D| means the quotient needs more than DW bits.
    povf_d = !dz_d && ({1'b0, absn_d[2*DW-1:DW]} >= absd_d);
  end

  logic [DW:0] step_r;
  logic [1:0]  step_digit;

  radix4_div_step #(.DW(DW)) u_step (
    .r_i     (rem_q),
    .bits_i  (lo_q[DW-1 -: 2]),
    .d1_i    (absd_q),
    .d2_i    ({absd_q, 1'b0}),
    .d3_i    (d3_q),
    .r_o     (step_r),
    .digit_o (step_digit)
  );

  logic          neg;
  logic [DW-1:0] quot_d, rem_d;
  logic          ovf_d;

  always_comb begin
    neg    = sn_q ^ sd_q;
    quot_d = neg ? -qu_q : qu_q;
    rem_d  = sn_q ? -rem_q[DW-1:0] : rem_q[DW-1:0];
    ovf_d  = povf_q || (neg ? (qu_q > Q_MIN) : (qu_q > Q_MAX));
    if (dz_q) begin
      quot_d = '0;
      rem_d  = n_q[DW-1:0];
      ovf_d  = 1'b0;
    end else if (ovf_d) begin
      quot_d = neg ? Q_MIN : Q_MAX;
      rem_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      remo_q      <= '0;
      dzo_q       <= 1'b0;
      ovfo_q      <= 1'b0;
      n_q         <= '0;
      d_q         <= '0;
      absd_q      <= '0;
      d3_q        <= '0;
      rem_q       <= '0;
      lo_q        <= '0;
      qu_q        <= '0;
      cnt_q       <= '0;
      sn_q        <= 1'b0;
      sd_q        <= 1'b0;
      dz_q        <= 1'b0;
      povf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            n_q        <= dividend;
            d_q        <= divisor;
            in_ready_q <= 1'b0;
            state_q    <= PREP;
          end
        end
        PREP: begin
          sn_q    <= n_q[2*DW-1];
          sd_q    <= d_q[DW-1];
          absd_q  <= absd_d;
          d3_q    <= d3_d;
          rem_q   <= {1'b0, absn_d[2*DW-1:DW]};
          lo_q    <= absn_d[DW-1:0];
          qu_q    <= '0;
          cnt_q   <= '0;
          dz_q    <= dz_d;
          povf_q  <= povf_d;
          state_q <= (dz_d || povf_d) ? FIX : ITER;
        end
        ITER: begin
          rem_q <= step_r;
          lo_q  <= lo_q << 2;
          qu_q  <= DW'({qu_q, step_digit});
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          quot_q      <= quot_d;
          remo_q      <= rem_d;
          dzo_q       <= dz_q;
          ovfo_q      <= ovf_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign div_zero  = dzo_q;
  assign overflow  = ovfo_q;

endmodule

// File: tb/tb_radix4_seq_divider.sv
// Scoreboard bench for radix4_seq_divider (DW=8): directed cases, backpressure,
// mid-operation reset and a randomized back-to-back run against a behavioural model.
module tb_radix4_seq_divider;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
    logic [3:0] lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        in_ready, out_valid, div_zero, overflow;
  logic [7:0]  quotient, remainder;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        exp_q[$];

  radix4_seq_divider #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [7:0] eq, input logic [7:0] er,
                              input logic edz, input logic eovf, input logic [3:0] elat);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz; e.ovf = eovf; e.lat = elat;
    return e;
  endfunction

  function automatic exp_t model(input logic signed [15:0] n, input logic signed [7:0] d);
    int ni, di, q, r, an, ad;
    exp_t e;
    ni = n; di = d;
    if (di == 0) return mk(8'h00, n[7:0], 1'b1, 1'b0, 4'd2);
    q = ni / di;
    r = ni % di;
    an = (ni < 0) ? -ni : ni;
    ad = (di < 0) ? -di : di;
    e.lat = ((an >> 8) >= ad) ? 4'd2 : 4'd6;
    e.dz = 1'b0;
    if (q > 127)       begin e.q = 8'h7F; e.r = 8'h00; e.ovf = 1'b1; end
    else if (q < -128) begin e.q = 8'h80; e.r = 8'h00; e.ovf = 1'b1; end
    else               begin e.q = q[7:0]; e.r = r[7:0]; e.ovf = 1'b0; end
    return e;
  endfunction

  task automatic send(input logic [15:0] n, input logic [7:0] d, input exp_t e);
    int unsigned guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    exp_q.push_back(e);
    in_valid = 1'b1; dividend = n; divisor = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic recv(input string name, input int unsigned hold);
    int unsigned edges = 0;
    exp_t e;
    do begin
      @(posedge clk); #1; edges++;
    end while (!out_valid && edges < 40);
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: unexpected result q=%h", name, quotient);
      return;
    end
    e = exp_q.pop_front();
    if (edges !== int'(e.lat)) begin
      errors++;
      $display("FAIL %s latency: got %0d edges required %0d", name, edges, e.lat);
    end
    checks++;
    if (quotient !== e.q) begin
      errors++; $display("FAIL %s quotient: got %h required %h", name, quotient, e.q);
    end
    checks++;
    if (remainder !== e.r) begin
      errors++; $display("FAIL %s remainder: got %h required %h", name, remainder, e.r);
    end
    checks++;
    if (div_zero !== e.dz) begin
      errors++; $display("FAIL %s div_zero: got %b required %b", name, div_zero, e.dz);
    end
    checks++;
    if (overflow !== e.ovf) begin
      errors++; $display("FAIL %s overflow: got %b required %b", name, overflow, e.ovf);
    end
    for (int unsigned i = 0; i < hold; i++) begin
      in_valid = 1'b1; dividend = 16'($urandom); divisor = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== e.q ||
          remainder !== e.r || div_zero !== e.dz || overflow !== e.ovf) begin
        errors++;
        $display("FAIL %s stall%0d: got v=%b rdy=%b q=%h r=%h dz=%b ov=%b required v=1 rdy=0 q=%h r=%h dz=%b ov=%b",
                 name, i, out_valid, in_ready, quotient, remainder, div_zero, overflow,
                 e.q, e.r, e.dz, e.ovf);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
    checks++;
    if (quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL %s idle_hold: got q=%h r=%h required q=%h r=%h", name, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (quotient !== 8'h00 || remainder !== 8'h00 || div_zero !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got q=%h r=%h dz=%b ov=%b required all 0", quotient, remainder, div_zero, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send(16'd100, 8'd7, mk(8'd14, 8'd2, 1'b0, 1'b0, 4'd6));
    recv("basic", 0);
  endtask

  task automatic test_signs();
    send(16'hFF9C, 8'd7, mk(8'hF2, 8'hFE, 1'b0, 1'b0, 4'd6));
    recv("neg_n", 0);
    send(16'd100, 8'hF9, mk(8'hF2, 8'h02, 1'b0, 1'b0, 4'd6));
    recv("neg_d", 0);
    send(16'hFF9C, 8'hF9, mk(8'd14, 8'hFE, 1'b0, 1'b0, 4'd6));
    recv("neg_both", 0);
  endtask

  task automatic test_div_zero();
    send(16'h04D2, 8'h00, mk(8'h00, 8'hD2, 1'b1, 1'b0, 4'd2));
    recv("div_zero", 0);
  endtask

  task automatic test_boundaries();
    send(16'h4000, 8'h80, mk(8'h80, 8'h00, 1'b0, 1'b0, 4'd6));
    recv("min_q", 0);
    send(16'hC000, 8'h80, mk(8'h7F, 8'h00, 1'b0, 1'b1, 4'd6));
    recv("post_ovf", 0);
    send(16'h7FFF, 8'h01, mk(8'h7F, 8'h00, 1'b0, 1'b1, 4'd2));
    recv("pre_ovf", 0);
    send(16'h8000, 8'h80, mk(8'h7F, 8'h00, 1'b0, 1'b1, 4'd2));
    recv("min_min", 0);
  endtask

  task automatic test_backpressure();
    send(16'd1000, 8'd9, mk(8'h6F, 8'h01, 1'b0, 1'b0, 4'd6));
    recv("bp_hold", 10);
    send(16'hFF38, 8'd13, mk(8'hF1, 8'hFB, 1'b0, 1'b0, 4'd6));
    recv("bp_next", 0);
  endtask

  task automatic test_reset_midop();
    int unsigned bad = 0;
    send(16'd12345, 8'd17, mk(8'h00, 8'h00, 1'b0, 1'b0, 4'd6));
    @(posedge clk); @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_hs: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    for (int unsigned i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL abort_quiet: got %0d cycles with out_valid=1 required 0", bad);
    end
    send(16'hFE01, 8'hFF, mk(8'h7F, 8'h00, 1'b0, 1'b1, 4'd2));
    recv("after_abort_ovf", 0);
    send(16'hFF38, 8'd13, mk(8'hF1, 8'hFB, 1'b0, 1'b0, 4'd6));
    recv("after_abort", 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] n;
    logic [7:0]  d;
    for (int unsigned i = 0; i < 24; i++) begin
      n = 16'($urandom);
      d = 8'($urandom);
      if (i % 3 == 0) n = 16'($signed(n[11:0]));
      if (i == 7) d = 8'h00;
      send(n, d, model(n, d));
      recv("random", (i % 5 == 0) ? 2 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_boundaries();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
